fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that moves a fixed number of words per requester into one downstream FIFO.
// States: IDLE | waiting for i_start.  RUN | granting words.  DONE | one-cycle completion pulse.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH          = 32,
    parameter int NUM_REQ             = 4,
    parameter int INPUT_CHANNEL_WIDTH = 11
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_start,
    input  logic [INPUT_CHANNEL_WIDTH-1:0]     i_input_feature_channel,
    input  logic [NUM_REQ-1:0]                 i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      i_req_data,
    output logic [NUM_REQ-1:0]                 o_req_ready,
    input  logic                               i_fifo_full,
    output logic                               o_fifo_wenable,
    output logic [DATA_WIDTH-1:0]              o_fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0]         o_grant_index,
    output logic                               o_busy,
    output logic                               o_done
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [INPUT_CHANNEL_WIDTH-1:0] r_budget;
    logic [INPUT_CHANNEL_WIDTH-1:0] r_cnt [NUM_REQ];
    logic [IDX_W-1:0]               r_ptr;
    logic [NUM_REQ-1:0]             w_elig;
    logic                           w_found;
    logic                           w_grant;
    logic                           w_all_done;
    logic [IDX_W-1:0]               w_gidx;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_elig[k] = i_req_valid[k] && (r_cnt[k] < r_budget);
        end
    end

    // Search upward from the pointer, wrapping at NUM_REQ-1.
    always_comb begin : p_search
        int               j;
        logic [IDX_W-1:0] idx;
        w_found = 1'b0;
        w_gidx  = '0;
        j       = 0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(r_ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            idx = IDX_W'(j);
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_gidx  = idx;
            end
        end
    end

    assign w_grant = (r_state == S_RUN) && !i_fifo_full && w_found;

    // Completion looks at counters after this cycle's increment.
    always_comb begin : p_all_done
        logic [INPUT_CHANNEL_WIDTH-1:0] nxt;
        w_all_done = 1'b1;
        nxt        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            nxt = r_cnt[k] + INPUT_CHANNEL_WIDTH'(w_grant && (w_gidx == IDX_W'(k)));
            if (nxt != r_budget) begin
                w_all_done = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_input_feature_channel != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_all_done) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready    = '0;
        o_fifo_wenable = w_grant;
        o_fifo_wdata   = '0;
        o_grant_index  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant && (w_gidx == IDX_W'(k))) begin
                o_req_ready[k] = 1'b1;
                o_fifo_wdata   = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
                o_grant_index  = w_gidx;
            end
        end
        o_busy = (r_state != S_IDLE);
        o_done = (r_state == S_DONE);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_budget <= '0;
            r_ptr    <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && i_start) begin
                r_budget <= i_input_feature_channel;
                r_ptr    <= '0;
                for (int k = 0; k < NUM_REQ; k++) begin
                    r_cnt[k] <= '0;
                end
            end else if (w_grant) begin
                r_cnt[w_gidx] <= r_cnt[w_gidx] + 1'b1;
                r_ptr         <= (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: expected grant order is queued as each
// step is driven and compared against every FIFO write the block issues.
module tb_fifo_write_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int CW = 11;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_start;
    logic [CW-1:0]    i_input_feature_channel;
    logic [NR-1:0]    i_req_valid;
    logic [NR*DW-1:0] i_req_data;
    logic [NR-1:0]    o_req_ready;
    logic             i_fifo_full;
    logic             o_fifo_wenable;
    logic [DW-1:0]    o_fifo_wdata;
    logic [1:0]       o_grant_index;
    logic             o_busy;
    logic             o_done;

    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .INPUT_CHANNEL_WIDTH(CW)) dut (
        .i_clock                 (clk),
        .i_reset                 (i_reset),
        .i_start                 (i_start),
        .i_input_feature_channel (i_input_feature_channel),
        .i_req_valid             (i_req_valid),
        .i_req_data              (i_req_data),
        .o_req_ready             (o_req_ready),
        .i_fifo_full             (i_fifo_full),
        .o_fifo_wenable          (o_fifo_wenable),
        .o_fifo_wdata            (o_fifo_wdata),
        .o_grant_index           (o_grant_index),
        .o_busy                  (o_busy),
        .o_done                  (o_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int cyc = 0;
    int writes = 0;
    int done_cnt = 0;
    int last_wr_cyc = 0;
    int done_cyc = 0;
    int mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every write.
    always @(negedge clk) begin
        cyc++;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_fifo_wenable) begin
            writes++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(o_grant_index), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("grant_index", 64'(o_grant_index), 64'(mon_e));
                chk("req_ready", 64'(o_req_ready), 64'(1) << mon_e);
                chk("wdata", 64'(o_fifo_wdata), 64'(i_req_data[mon_e*DW +: DW]));
            end
        end else begin
            chk("noWr_ready", 64'(o_req_ready), 64'd0);
            chk("noWr_wdata", 64'(o_fifo_wdata), 64'd0);
            chk("noWr_index", 64'(o_grant_index), 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            i_req_data[k*DW +: DW] = $urandom();
        end
    endtask

    task automatic start_job(input int budget);
        i_input_feature_channel = CW'(budget);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < max_cyc) begin
            step();
            n++;
        end
        chk(tag, 64'(done_cnt), 64'(d0 + 1));
    endtask

    task automatic push_rr(input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < NR; k++) begin
                exp_q.push_back(k);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(o_req_ready), 64'd0);
        chk({tag, "_wen"}, 64'(o_fifo_wenable), 64'd0);
        chk({tag, "_wdata"}, 64'(o_fifo_wdata), 64'd0);
        chk({tag, "_index"}, 64'(o_grant_index), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        int w0;
        int d0;
        int n;
        i_reset = 1'b1;
        i_start = 1'b0;
        i_input_feature_channel = '0;
        i_req_valid = '0;
        i_req_data = '0;
        i_fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        i_reset = 1'b0;
        step();

        // Budget 3, all valid: 0,1,2,3 three times, done right after last write.
        i_req_valid = '1;
        push_rr(3);
        w0 = writes;
        d0 = done_cnt;
        start_job(3);
        chk("t1_busy", 64'(o_busy), 64'd1);
        wait_done(60, "t1_done");
        chk("t1_writes", 64'(writes - w0), 64'd12);
        chk("t1_done_after_last", 64'(done_cyc), 64'(last_wr_cyc + 1));
        chk("t1_queue", 64'(exp_q.size()), 64'd0);
        step();
        step();
        chk("t1_done_once", 64'(done_cnt), 64'(d0 + 1));
        chk("t1_idle", 64'(o_busy), 64'd0);

        // Budget 2, only 1 and 3 valid: alternate, then stall until 0 and 2 arrive.
        i_req_valid = 4'b1010;
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(3);
        w0 = writes;
        d0 = done_cnt;
        start_job(2);
        repeat (15) step();
        chk("t2_partial_writes", 64'(writes - w0), 64'd4);
        chk("t2_stalled_busy", 64'(o_busy), 64'd1);
        chk("t2_no_done", 64'(done_cnt), 64'(d0));
        chk("t2_queue_mid", 64'(exp_q.size()), 64'd0);
        i_req_valid = 4'b0101;
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
        wait_done(40, "t2_done");
        chk("t2_writes", 64'(writes - w0), 64'd8);

        // Full for 5 cycles mid-job, then a stray i_start during RUN.
        i_req_valid = '1;
        exp_q.push_back(0); exp_q.push_back(1);
        w0 = writes;
        start_job(2);
        step();
        step();
        i_fifo_full = 1'b1;
        n = writes;
        #1;
        chk("t3_full_wen", 64'(o_fifo_wenable), 64'd0);
        chk("t3_full_ready", 64'(o_req_ready), 64'd0);
        repeat (4) step();
        step();
        chk("t3_full_no_writes", 64'(writes - n), 64'd0);
        exp_q.push_back(2); exp_q.push_back(3);
        push_rr(1);
        i_fifo_full = 1'b0;
        step();
        i_input_feature_channel = CW'(1);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_done(40, "t3_done");
        chk("t3_writes", 64'(writes - w0), 64'd8);
        chk("t3_queue", 64'(exp_q.size()), 64'd0);

        // Budget 0: one busy cycle with done, no writes.
        w0 = writes;
        d0 = done_cnt;
        start_job(0);
        chk("t4_busy", 64'(o_busy), 64'd1);
        chk("t4_done", 64'(o_done), 64'd1);
        step();
        chk("t4_busy_after", 64'(o_busy), 64'd0);
        chk("t4_done_after", 64'(o_done), 64'd0);
        chk("t4_writes", 64'(writes - w0), 64'd0);
        chk("t4_done_count", 64'(done_cnt), 64'(d0 + 1));

        // Reset after 5 writes of budget 4, then a fresh full job.
        push_rr(1);
        exp_q.push_back(0);
        w0 = writes;
        d0 = done_cnt;
        start_job(4);
        n = 0;
        while ((writes - w0) < 5 && n < 50) begin
            step();
            n++;
        end
        chk("t5_five_writes", 64'(writes - w0), 64'd5);
        i_reset = 1'b1;
        #1;
        chk_all_zero("t5_reset");
        step();
        step();
        i_reset = 1'b0;
        step();
        step();
        chk("t5_waits_idle", 64'(o_busy), 64'd0);
        chk("t5_no_done", 64'(done_cnt), 64'(d0));
        chk("t5_queue", 64'(exp_q.size()), 64'd0);
        push_rr(4);
        w0 = writes;
        start_job(4);
        wait_done(100, "t5_done");
        chk("t5_writes", 64'(writes - w0), 64'd16);
        chk("t5_queue_end", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
